// File: rtl/wb_frame_reader.sv
// rtl/wb_frame_reader.sv - Wishbone read master streaming a frame as little-endian bytes
// Optional ack-wait timeout enabled by defining WB_TIMEOUT_EN.
module wb_frame_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        byte_last_o,
  input  logic        byte_ready_i
);

  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

  state_t      state_q, state_n;
  logic [31:0] adr_q, adr_n, buf_q, buf_n;
  logic [15:0] rem_q, rem_n, rem_dec;
  logic [1:0]  idx_q, idx_n, idx_inc;
  logic [7:0]  byte_q, byte_n;
  logic        err_q, err_n, done_q, done_n, busy_q, busy_n;
  logic        cyc_q, cyc_n, valid_q, valid_n, last_q, last_n;
  logic        tmo_hit;
  logic        unused_ok;

`ifdef WB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q;

  // Restarts whenever REQ is entered or left, so each request gets a full window.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != REQ || state_n != REQ) tmo_q <= '0;
    else                                              tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign unused_ok = ^base_adr_i[1:0];
`else
  assign tmo_hit   = 1'b0;
  assign unused_ok = ^{base_adr_i[1:0], TIMEOUT_CYCLES == 0};
`endif

  assign rem_dec = rem_q - 16'd1;
  assign idx_inc = idx_q + 2'd1;

  always_comb begin
    state_n = state_q;
    adr_n   = adr_q;
    rem_n   = rem_q;
    buf_n   = buf_q;
    idx_n   = idx_q;
    byte_n  = byte_q;
    err_n   = err_q;
    done_n  = 1'b0;
    cyc_n   = 1'b0;
    valid_n = 1'b0;
    last_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_n = 1'b0;
          if (len_i != 16'd0) begin
            adr_n   = {base_adr_i[31:2], 2'b00};
            rem_n   = len_i;
            cyc_n   = 1'b1;
            state_n = REQ;
          end else begin
            rem_n   = 16'd0;
            state_n = DONE;
          end
        end
      end
      REQ: begin
        if (wb_err_i || (!wb_ack_i && tmo_hit)) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else if (wb_ack_i) begin
          buf_n   = wb_dat_i;
          idx_n   = 2'd0;
          byte_n  = wb_dat_i[7:0];
          valid_n = 1'b1;
          last_n  = (rem_q == 16'd1);
          state_n = SEND;
        end else begin
          cyc_n = 1'b1;
        end
      end
      SEND: begin
        valid_n = 1'b1;
        last_n  = last_q;
        if (byte_ready_i) begin
          rem_n = rem_dec;
          if (rem_dec == 16'd0) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else if (idx_q == 2'd3) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            adr_n   = adr_q + 32'd4;
            cyc_n   = 1'b1;
            state_n = REQ;
          end else begin
            idx_n  = idx_inc;
            byte_n = buf_q[{idx_inc, 3'b000} +: 8];
            last_n = (rem_dec == 16'd1);
          end
        end
      end
      DONE: begin
        // A zero-length start arrives here without the pulse armed; raise it one cycle later.
        if (done_q) state_n = IDLE;
        else        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cyc_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      adr_q   <= adr_n;
      rem_q   <= rem_n;
      buf_q   <= buf_n;
      idx_q   <= idx_n;
      byte_q  <= byte_n;
      err_q   <= err_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      cyc_q   <= cyc_n;
      valid_q <= valid_n;
      last_q  <= last_n;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = 4'hF;
  assign wb_we_o      = 1'b0;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign byte_last_o  = last_q;

endmodule

// File: tb/tb_wb_frame_reader.sv
// tb/tb_wb_frame_reader.sv - scoreboard bench for wb_frame_reader with randomized frames
module tb_wb_frame_reader;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] base_adr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic [7:0]  byte_o;
  logic        byte_valid_o, byte_last_o;
  logic        byte_ready_i = 1'b1;

  wb_frame_reader #(.TIMEOUT_CYCLES(255)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
    .base_adr_i(base_adr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_last_o(byte_last_o), .byte_ready_i(byte_ready_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       word_end;
  } exp_byte_t;

  exp_byte_t   exp_bytes[$];
  logic [31:0] exp_adr[$];
  logic        exp_done[$];
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 driven by the main sequence
  int max_wait = 0;
  logic slave_hang = 1'b0;
  logic err_en = 1'b0;
  logic [31:0] err_adr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Wishbone slave: random wait states, checks request order against the model.
  initial begin
    int wait_left = 0;
    int prev_term = 0;
    forever begin
      @(posedge wb_clk_i); #2;
      if (prev_term != 0) begin
        chk("valid_after_term", byte_valid_o, prev_term == 1);
        chk("cyc_drop_after_term", wb_cyc_o, 0);
      end
      prev_term = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (wb_cyc_o && wb_stb_o && !slave_hang) begin
        if (wait_left > 0) wait_left--;
        else begin
          chk("adr_expected", exp_adr.size() != 0, 1);
          if (exp_adr.size() != 0) chk("wb_adr", wb_adr_o, exp_adr.pop_front());
          chk("wb_sel", wb_sel_o, 4'hF);
          chk("wb_we", wb_we_o, 0);
          if (err_en && wb_adr_o == err_adr) begin
            wb_err_i = 1'b1;
            prev_term = 2;
          end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
            prev_term = 1;
          end
          wait_left = $urandom_range(0, max_wait);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge wb_clk_i); #2;
      if (ready_mode == 0) byte_ready_i = 1'b1;
      else if (ready_mode == 1) byte_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Stream and completion monitor.
  initial begin
    logic hold_pending = 1'b0;
    logic [7:0] hold_byte = '0;
    logic hold_last = 1'b0;
    logic want_cyc = 1'b0;
    logic want_done = 1'b0;
    exp_byte_t e;
    forever begin
      @(negedge wb_clk_i);
      if (hold_pending) begin
        chk("hold_valid", byte_valid_o, 1);
        chk("hold_byte", byte_o, hold_byte);
        chk("hold_last", byte_last_o, hold_last);
        hold_pending = 1'b0;
      end
      if (want_cyc) chk("back_to_back_cyc", wb_cyc_o, 1);
      if (want_done) chk("done_after_last", done_o, 1);
      want_cyc = 1'b0;
      want_done = 1'b0;
      if (byte_valid_o && byte_ready_i) begin
        chk("byte_expected", exp_bytes.size() != 0, 1);
        if (exp_bytes.size() != 0) begin
          e = exp_bytes.pop_front();
          chk("byte_data", byte_o, e.data);
          chk("byte_last", byte_last_o, e.last);
          want_cyc = e.word_end;
          want_done = e.last;
        end
      end else if (byte_valid_o) begin
        hold_pending = 1'b1;
        hold_byte = byte_o;
        hold_last = byte_last_o;
      end
      if (done_o) begin
        done_cnt++;
        chk("busy_during_done", busy_o, 1);
        chk("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) chk("err_at_done", err_o, exp_done.pop_front());
      end
    end
  end

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
    @(posedge wb_clk_i); #2;
    start_i = 1'b1; base_adr_i = b; len_i = l;
    @(posedge wb_clk_i); #2;
    start_i = 1'b0; base_adr_i = $urandom; len_i = 16'($urandom);
  endtask

  // Reference model: word addresses and byte sequence derived from length, base and memory.
  task automatic run_frame(input logic [31:0] b, input int len, input int err_word);
    logic [31:0] al, a, w;
    int nwords, nbytes, lastw, d0;
    exp_byte_t e;
    al = {b[31:2], 2'b00};
    nwords = (len + 3) / 4;
    for (int i = 0; i < nwords; i++) begin
      a = al + 32'(4 * i);
      if (!mem.exists(a)) mem[a] = $urandom;
    end
    err_en = (err_word >= 0 && err_word < nwords);
    err_adr = al + 32'(4 * err_word);
    lastw = err_en ? err_word : nwords - 1;
    nbytes = err_en ? 4 * err_word : len;
    for (int i = 0; i <= lastw; i++) exp_adr.push_back(al + 32'(4 * i));
    for (int k = 0; k < nbytes; k++) begin
      w = mem[al + 32'(4 * (k / 4))];
      e.data = 8'(w >> (8 * (k % 4)));
      e.last = (k == len - 1);
      e.word_end = (k % 4 == 3) && (k != len - 1);
      exp_bytes.push_back(e);
    end
    exp_done.push_back(err_en);
    d0 = done_cnt;
    pulse_start(b, 16'(len));
    chk("cyc_cycle1", wb_cyc_o, len != 0);
    chk("busy_cycle1", busy_o, 1);
    chk("err_cleared", err_o, 0);
    if (len == 0) begin
      chk("zero_len_no_done_c1", done_o, 0);
      @(posedge wb_clk_i); #2;
      chk("zero_len_done_c2", done_o, 1);
      chk("zero_len_no_cyc", wb_cyc_o, 0);
    end
    for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
      @(posedge wb_clk_i); #3;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("busy_low_after_done", busy_o, 0);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("adr_left", exp_adr.size(), 0);
    err_en = 1'b0;
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int cnt;
    repeat (3) @(posedge wb_clk_i);
    #2;
    wb_rst_i = 1'b0;
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_sel", wb_sel_o, 4'hF);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_valid", byte_valid_o, 0);
    chk("rst_byte", byte_o, 0);
    chk("rst_busy_done_err", {busy_o, done_o, err_o, byte_last_o}, 0);

    mem[32'h100] = 32'h44332211;
    mem[32'h104] = 32'h88776655;
    run_frame(32'h100, 8, -1);

    mem[32'h200] = 32'hDDCCBBAA;
    mem[32'h204] = 32'h000000EE;
    max_wait = 2;
    fork
      run_frame(32'h203, 5, -1);
      begin
        repeat (3) @(posedge wb_clk_i);
        #2; start_i = 1'b1; base_adr_i = 32'h0; len_i = 16'd0;
        @(posedge wb_clk_i); #2; start_i = 1'b0;
      end
    join

    ready_mode = 2;
    byte_ready_i = 1'b0;
    fork
      run_frame(32'h300, 4, -1);
      begin
        for (int i = 0; i < 200 && !byte_valid_o; i++) begin
          @(posedge wb_clk_i); #2;
        end
        repeat (10) @(posedge wb_clk_i);
        #2;
        chk("stalled_valid", byte_valid_o, 1);
        byte_ready_i = 1'b1;
      end
    join
    ready_mode = 0;

    run_frame(32'h400, 8, 1);
    chk("err_sticky", err_o, 1);
    run_frame(32'h500, 3, -1);
    run_frame(32'h600, 0, -1);

    ready_mode = 1;
    for (int f = 0; f < 14; f++) begin
      int len, ew;
      len = $urandom_range(1, 20);
      ew = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (len + 3) / 4 - 1) : -1;
      run_frame($urandom, len, ew);
    end
    ready_mode = 0;

    slave_hang = 1'b1;
`ifdef WB_TIMEOUT_EN
    exp_done.push_back(1'b1);
    cnt = done_cnt;
    pulse_start(32'h700, 16'd4);
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 1000 && wb_cyc_o; i++) begin
        hi++;
        @(posedge wb_clk_i); #3;
      end
      chk("timeout_cyc_cycles", hi, 255);
    end
    repeat (3) @(posedge wb_clk_i);
    #3;
    chk("timeout_done", done_cnt, cnt + 1);
    chk("timeout_err", err_o, 1);
`endif
    pulse_start(32'h800, 16'd8);
    repeat (3) @(posedge wb_clk_i);
    #2;
    chk("req_waiting", wb_cyc_o, 1);
    cnt = done_cnt;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #2;
    wb_rst_i = 1'b0;
    chk("rst_in_req_cyc", wb_cyc_o, 0);
    chk("rst_in_req_busy", busy_o, 0);
    chk("rst_in_req_valid", byte_valid_o, 0);
    repeat (5) @(posedge wb_clk_i);
    #3;
    chk("rst_in_req_no_done", done_cnt, cnt);
    slave_hang = 1'b0;

    run_frame(32'h900, 6, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
